// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for output-side I/O blocks: channel state encodings
// and small elaboration-time helpers.
package pulse_stretcher_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HOLD = ST_HOLD,
    GAP  = ST_GAP
  } ps_state_t;

  // Larger of two cycle counts; sizes a counter shared by HOLD and GAP.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_channel.sv
// One stretcher channel: rising-edge detect, HOLD/GAP timing FSM and a
// saturating queue of events that arrive while the channel is busy.
module pulse_stretcher_channel
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD_CNT_MAX   = 6250000,
  parameter int GAP_CNT_MAX    = 6250000,
  parameter int PEND_MAX       = 3,
  parameter int HOLD_CNT_WIDTH = $clog2(max_int(HOLD_CNT_MAX, GAP_CNT_MAX)) + 1,
  parameter int PEND_CNT_WIDTH = $clog2(PEND_MAX) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic stretched,
  output logic busy,
  output logic dropped
);

  localparam int CW = HOLD_CNT_WIDTH;
  localparam int PW = PEND_CNT_WIDTH;

  ps_state_t       state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   pend, pend_nxt;
  logic            trig_prev;
  logic            rise;
  logic            hold_done;
  logic            gap_done;
  logic            drop_nxt;

  assign rise      = trigger & ~trig_prev;
  assign hold_done = (cnt == CW'(HOLD_CNT_MAX - 1));
  assign gap_done  = (cnt == CW'(GAP_CNT_MAX - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    drop_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (hold_done) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (gap_done) begin
          cnt_nxt = '0;
          // A fresh edge on the final gap cycle is consumed directly and
          // leaves the queue untouched.
          if (rise) begin
            state_nxt = HOLD;
          end else if (pend != '0) begin
            state_nxt = HOLD;
            pend_nxt  = pend - 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    if (rise && ((state == HOLD) || ((state == GAP) && !gap_done))) begin
      if (pend == PW'(PEND_MAX)) begin
        drop_nxt = 1'b1;
      end else begin
        pend_nxt = pend + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= '0;
      trig_prev <= 1'b0;
      stretched <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pend      <= pend_nxt;
      trig_prev <= trigger;
      // Outputs follow the next state so they line up with it cycle-exactly.
      stretched <= (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE) || (pend_nxt != '0);
      dropped   <= drop_nxt;
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: WIDTH independent channels that turn short
// internal events into pulses of fixed high time and minimum low gap.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int HOLD_CNT_MAX   = 6250000,
  parameter int GAP_CNT_MAX    = 6250000,
  parameter int PEND_MAX       = 3,
  parameter int HOLD_CNT_WIDTH = $clog2(max_int(HOLD_CNT_MAX, GAP_CNT_MAX)) + 1,
  parameter int PEND_CNT_WIDTH = $clog2(PEND_MAX) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] trigger,
  output logic [WIDTH-1:0] stretched,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] dropped
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pulse_stretcher_channel #(
      .HOLD_CNT_MAX  (HOLD_CNT_MAX),
      .GAP_CNT_MAX   (GAP_CNT_MAX),
      .PEND_MAX      (PEND_MAX),
      .HOLD_CNT_WIDTH(HOLD_CNT_WIDTH),
      .PEND_CNT_WIDTH(PEND_CNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .trigger  (trigger[i]),
      .stretched(stretched[i]),
      .busy     (busy[i]),
      .dropped  (dropped[i])
    );
  end

endmodule
